// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the HI/LO multiply sequencer.
package mult_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned GUARD_DEF = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StGuard = 2'd2,
        StWait  = 2'd3
    } state_e;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO registers with independent write enables and the MFHI/MFLO read mux.
module hilo_regs
    import mult_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] hi_wdata,
    input  logic [XLEN-1:0] lo_wdata,
    input  logic            RD_HI,
    output logic [XLEN-1:0] RDATA
);

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_wdata;
            if (lo_we) lo_q <= lo_wdata;
        end
    end

    assign RDATA = RD_HI ? hi_q : lo_q;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequencer between EX and the serial multiplier: issues MULT/MULTU, captures the
// product into HI/LO, stalls on HI/LO hazards and aborts the multiplier on flush.
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned GUARD = GUARD_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ,
    input  logic              REQ_SGN,
    input  logic [XLEN-1:0]   OPA,
    input  logic [XLEN-1:0]   OPB,
    input  logic              MTHI,
    input  logic              MTLO,
    input  logic [XLEN-1:0]   WDATA,
    input  logic              RD_HI,
    input  logic              RD_LO,
    input  logic              FLUSH,
    output logic              STALL,
    output logic              BUSY,
    output logic [XLEN-1:0]   RDATA,
    output logic              MST,
    output logic              MSGN,
    output logic [XLEN-1:0]   SRCA,
    output logic [XLEN-1:0]   SRCB,
    output logic              MRST,
    input  logic [2*XLEN-1:0] PROD,
    input  logic              PRODV
);

    localparam int unsigned CW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    state_e          state_q;
    logic [CW-1:0]   gcnt_q;
    logic            abort_q;
    logic            idle_go;
    logic            capture;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] hi_wdata;
    logic [XLEN-1:0] lo_wdata;

    assign BUSY  = (state_q != StIdle);
    assign STALL = BUSY & (REQ | RD_HI | RD_LO | MTHI | MTLO);
    assign MRST  = ~RST_N | abort_q;

    // A flush in the capture cycle squashes the product along with the instruction.
    assign idle_go  = (state_q == StIdle) & ~FLUSH;
    assign capture  = (state_q == StWait) & PRODV & ~FLUSH;
    assign hi_we    = capture | (idle_go & ~REQ & MTHI);
    assign lo_we    = capture | (idle_go & ~REQ & MTLO);
    assign hi_wdata = capture ? PROD[2*XLEN-1:XLEN] : WDATA;
    assign lo_wdata = capture ? PROD[XLEN-1:0] : WDATA;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            gcnt_q  <= '0;
            abort_q <= 1'b0;
            MST     <= 1'b0;
            MSGN    <= 1'b0;
            SRCA    <= '0;
            SRCB    <= '0;
        end else begin
            abort_q <= 1'b0;
            MST     <= 1'b0;
            if (FLUSH && BUSY) begin
                state_q <= StIdle;
                abort_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (REQ && !FLUSH) begin
                            SRCA    <= OPA;
                            SRCB    <= OPB;
                            MSGN    <= REQ_SGN;
                            MST     <= 1'b1;
                            state_q <= StIssue;
                        end
                    end
                    StIssue: begin
                        gcnt_q  <= CW'(GUARD - 1);
                        state_q <= StGuard;
                    end
                    // The multiplier still shows the previous PRODV here; ignore it.
                    StGuard: begin
                        if (gcnt_q == '0) state_q <= StWait;
                        else              gcnt_q  <= gcnt_q - 1'b1;
                    end
                    StWait: begin
                        if (PRODV) state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    hilo_regs #(
        .XLEN(XLEN)
    ) u_hilo_regs (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata),
        .RD_HI    (RD_HI),
        .RDATA    (RDATA)
    );

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a behavioural serial multiplier model.
module tb_mult_hilo_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ = 1'b0;
    logic        REQ_SGN = 1'b0;
    logic [31:0] OPA = '0;
    logic [31:0] OPB = '0;
    logic        MTHI = 1'b0;
    logic        MTLO = 1'b0;
    logic [31:0] WDATA = '0;
    logic        RD_HI = 1'b0;
    logic        RD_LO = 1'b0;
    logic        FLUSH = 1'b0;
    logic        STALL;
    logic        BUSY;
    logic [31:0] RDATA;
    logic        MST;
    logic        MSGN;
    logic [31:0] SRCA;
    logic [31:0] SRCB;
    logic        MRST;
    logic [63:0] PROD;
    logic        PRODV;

    int tests_run = 0;
    int tests_failed = 0;
    int mst_pulses = 0;
    int lat = 4;

    // Multiplier model state
    logic [31:0] m_a, m_b;
    logic        m_s;
    logic        m_clr;
    int          m_cnt = 0;

    always #5 CLK = ~CLK;

    mult_hilo_ctrl #(
        .XLEN  (32),
        .GUARD (2)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .REQ_SGN (REQ_SGN),
        .OPA     (OPA),
        .OPB     (OPB),
        .MTHI    (MTHI),
        .MTLO    (MTLO),
        .WDATA   (WDATA),
        .RD_HI   (RD_HI),
        .RD_LO   (RD_LO),
        .FLUSH   (FLUSH),
        .STALL   (STALL),
        .BUSY    (BUSY),
        .RDATA   (RDATA),
        .MST     (MST),
        .MSGN    (MSGN),
        .SRCA    (SRCA),
        .SRCB    (SRCB),
        .MRST    (MRST),
        .PROD    (PROD),
        .PRODV   (PRODV)
    );

    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Serial multiplier: stale PRODV lingers one cycle after start, result after lat cycles.
    always @(posedge CLK) begin
        if (MRST) begin
            PRODV <= 1'b0;
            PROD  <= '0;
            m_cnt <= 0;
            m_clr <= 1'b0;
        end else begin
            m_clr <= 1'b0;
            if (MST) begin
                m_clr <= 1'b1;
                m_cnt <= lat;
                m_a   <= SRCA;
                m_b   <= SRCB;
                m_s   <= MSGN;
            end else begin
                if (m_clr) PRODV <= 1'b0;
                if (m_cnt != 0) begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        PRODV <= 1'b1;
                        PROD  <= model_prod(m_a, m_b, m_s);
                    end
                end
            end
        end
    end

    always @(negedge CLK) if (MST) mst_pulses <= mst_pulses + 1;

    always @(negedge CLK) begin
        if (RST_N) assert (!(REQ && (MTHI || MTLO))) else $error("REQ with MTHI/MTLO");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        REQ = 0; REQ_SGN = 0; OPA = '0; OPB = '0; MTHI = 0; MTLO = 0;
        WDATA = '0; RD_HI = 0; RD_LO = 0; FLUSH = 0;
    endtask

    task automatic wait_idle(input int budget, output bit timeout, output int cycles,
                             output bit stall_bad);
        timeout = 1; cycles = 0; stall_bad = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK); #1;
            if (!BUSY) begin
                timeout = 0;
                break;
            end
            cycles++;
            if ((REQ | RD_HI | RD_LO | MTHI | MTLO) && STALL !== 1'b1) stall_bad = 1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        RST_N = 0;
        repeat (2) @(negedge CLK);
        #1;
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b exp 0", BUSY); end
        tests_run++; if (MRST !== 1'b1) begin tests_failed++; $display("FAIL rst_mrst: got %b exp 1", MRST); end
        tests_run++; if (SRCA !== 32'h0 || MSGN !== 1'b0 || MST !== 1'b0) begin tests_failed++; $display("FAIL rst_regs: got %h/%b/%b exp 0/0/0", SRCA, MSGN, MST); end
        RST_N = 1;
        @(negedge CLK); #1;
        tests_run++; if (MRST !== 1'b0) begin tests_failed++; $display("FAIL rst_mrst_rel: got %b exp 0", MRST); end
        MTHI = 1; WDATA = 32'h55;
        @(negedge CLK); MTHI = 0; MTLO = 1; WDATA = 32'h66;
        @(negedge CLK); MTLO = 0;
        lat = 20;
        REQ = 1; OPA = 32'd9; OPB = 32'd9;
        @(negedge CLK); REQ = 0;
        repeat (4) @(negedge CLK);
        RD_HI = 1;
        #2 RST_N = 0;
        #1;
        tests_run++; if (BUSY !== 1'b0 || STALL !== 1'b0) begin tests_failed++; $display("FAIL rst_async_busy: got %b/%b exp 0/0", BUSY, STALL); end
        tests_run++; if (MRST !== 1'b1 || MST !== 1'b0) begin tests_failed++; $display("FAIL rst_async_mrst: got %b/%b exp 1/0", MRST, MST); end
        tests_run++; if (RDATA !== 32'h0) begin tests_failed++; $display("FAIL rst_async_hi: got %h exp 0", RDATA); end
        RD_HI = 0; #1;
        tests_run++; if (RDATA !== 32'h0) begin tests_failed++; $display("FAIL rst_async_lo: got %h exp 0", RDATA); end
        @(negedge CLK);
        RST_N = 1;
        idle_inputs();
        @(negedge CLK);
    endtask

    task automatic test_unsigned();
        bit to, sb;
        int cyc, base;
        lat = 4; base = mst_pulses;
        @(negedge CLK); REQ = 1; REQ_SGN = 0; OPA = 32'd3; OPB = 32'd5;
        @(negedge CLK); REQ = 0; RD_LO = 1; #1;
        tests_run++; if (STALL !== 1'b1) begin tests_failed++; $display("FAIL uns_stall: got %b exp 1", STALL); end
        wait_idle(60, to, cyc, sb);
        tests_run++; if (to !== 1'b0 || sb !== 1'b0) begin tests_failed++; $display("FAIL uns_wait: got timeout %b stall_drop %b exp 0 0", to, sb); end
        tests_run++; if (STALL !== 1'b0 || RDATA !== 32'h0000000F) begin tests_failed++; $display("FAIL uns_lo: got %b/%h exp 0/0000000f", STALL, RDATA); end
        RD_LO = 0; RD_HI = 1; #1;
        tests_run++; if (RDATA !== 32'h0) begin tests_failed++; $display("FAIL uns_hi: got %h exp 0", RDATA); end
        RD_HI = 0;
        tests_run++; if (mst_pulses - base !== 1) begin tests_failed++; $display("FAIL uns_mst: got %0d exp 1", mst_pulses - base); end
    endtask

    task automatic test_signed();
        bit to, sb;
        int cyc;
        lat = 4;
        @(negedge CLK); REQ = 1; REQ_SGN = 0; OPA = 32'hFFFFFFFF; OPB = 32'hFFFFFFFF;
        @(negedge CLK); REQ = 0;
        wait_idle(60, to, cyc, sb);
        RD_HI = 1; #1;
        tests_run++; if (to !== 1'b0 || RDATA !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL umax_hi: got %h exp fffffffe", RDATA); end
        RD_HI = 0; #1;
        tests_run++; if (RDATA !== 32'h00000001) begin tests_failed++; $display("FAIL umax_lo: got %h exp 00000001", RDATA); end
        @(negedge CLK); REQ = 1; REQ_SGN = 1; OPA = 32'hFFFFFFFE; OPB = 32'd3;
        @(negedge CLK); #1;
        tests_run++; if (MST !== 1'b1 || MSGN !== 1'b1) begin tests_failed++; $display("FAIL sgn_issue: got %b/%b exp 1/1", MST, MSGN); end
        REQ = 0;
        wait_idle(60, to, cyc, sb);
        RD_HI = 1; #1;
        tests_run++; if (to !== 1'b0 || RDATA !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL sgn_hi: got %h exp ffffffff", RDATA); end
        RD_HI = 0; #1;
        tests_run++; if (RDATA !== 32'hFFFFFFFA) begin tests_failed++; $display("FAIL sgn_lo: got %h exp fffffffa", RDATA); end
    endtask

    task automatic test_back_to_back();
        bit to, sb;
        int cyc;
        lat = 5;
        @(negedge CLK); REQ = 1; REQ_SGN = 0; OPA = 32'd2; OPB = 32'd2;
        @(negedge CLK); OPA = 32'd7; OPB = 32'd6; #1;
        tests_run++; if (STALL !== 1'b1) begin tests_failed++; $display("FAIL b2b_hold: got %b exp 1", STALL); end
        wait_idle(60, to, cyc, sb);
        tests_run++; if (to !== 1'b0 || STALL !== 1'b0) begin tests_failed++; $display("FAIL b2b_release: got timeout %b stall %b exp 0 0", to, STALL); end
        @(negedge CLK); #1;
        tests_run++; if (MST !== 1'b1 || SRCA !== 32'd7 || SRCB !== 32'd6) begin tests_failed++; $display("FAIL b2b_issue: got %b/%h/%h exp 1/7/6", MST, SRCA, SRCB); end
        REQ = 0;
        wait_idle(60, to, cyc, sb);
        tests_run++; if (to !== 1'b0 || cyc < lat) begin tests_failed++; $display("FAIL b2b_busy: got %0d cycles exp >= %0d", cyc, lat); end
        RD_LO = 1; #1;
        tests_run++; if (RDATA !== 32'h2A) begin tests_failed++; $display("FAIL b2b_lo: got %h exp 2a", RDATA); end
        RD_LO = 0; RD_HI = 1; #1;
        tests_run++; if (RDATA !== 32'h0) begin tests_failed++; $display("FAIL b2b_hi: got %h exp 0", RDATA); end
        RD_HI = 0;
    endtask

    task automatic test_flush();
        bit found;
        int base;
        @(negedge CLK); MTHI = 1; WDATA = 32'h1234;
        @(negedge CLK); MTHI = 0; MTLO = 1; WDATA = 32'h5678;
        @(negedge CLK); MTLO = 0;
        lat = 10; base = mst_pulses;
        REQ = 1; REQ_SGN = 1; OPA = 32'h10; OPB = 32'h10;
        @(negedge CLK); REQ = 0;
        repeat (3) @(negedge CLK);
        #1;
        tests_run++; if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL fl_busy_pre: got %b exp 1", BUSY); end
        FLUSH = 1;
        @(negedge CLK); #1; FLUSH = 0;
        tests_run++; if (BUSY !== 1'b0 || MRST !== 1'b1) begin tests_failed++; $display("FAIL fl_abort: got busy %b mrst %b exp 0 1", BUSY, MRST); end
        @(negedge CLK); #1;
        tests_run++; if (MRST !== 1'b0) begin tests_failed++; $display("FAIL fl_mrst_pulse: got %b exp 0", MRST); end
        repeat (15) @(negedge CLK);
        RD_HI = 1; #1;
        tests_run++; if (BUSY !== 1'b0 || RDATA !== 32'h1234) begin tests_failed++; $display("FAIL fl_hi: got %b/%h exp 0/1234", BUSY, RDATA); end
        RD_HI = 0; #1;
        tests_run++; if (RDATA !== 32'h5678) begin tests_failed++; $display("FAIL fl_lo: got %h exp 5678", RDATA); end
        tests_run++; if (mst_pulses - base !== 1) begin tests_failed++; $display("FAIL fl_mst: got %0d exp 1", mst_pulses - base); end
        // Flush in IDLE drops REQ and MTHI.
        @(negedge CLK); REQ = 1; FLUSH = 1; OPA = 32'd1; OPB = 32'd1;
        @(negedge CLK); REQ = 0; MTHI = 1; WDATA = 32'hFFFF; #1;
        tests_run++; if (BUSY !== 1'b0 || MST !== 1'b0) begin tests_failed++; $display("FAIL fl_idle_req: got %b/%b exp 0/0", BUSY, MST); end
        @(negedge CLK); MTHI = 0; FLUSH = 0; RD_HI = 1; #1;
        tests_run++; if (RDATA !== 32'h1234) begin tests_failed++; $display("FAIL fl_idle_mthi: got %h exp 1234", RDATA); end
        RD_HI = 0;
        // Flush coinciding with the capture edge.
        lat = 4;
        @(negedge CLK); REQ = 1; REQ_SGN = 0; OPA = 32'h10; OPB = 32'h10;
        @(negedge CLK); REQ = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK); #1;
            if (PRODV && BUSY) begin
                found = 1;
                FLUSH = 1;
                break;
            end
        end
        tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL fl_cap_reach: got %b exp 1", found); end
        @(negedge CLK); #1; FLUSH = 0; RD_LO = 1; #1;
        tests_run++; if (BUSY !== 1'b0 || RDATA !== 32'h5678) begin tests_failed++; $display("FAIL fl_cap_lo: got %b/%h exp 0/5678", BUSY, RDATA); end
        RD_LO = 0; RD_HI = 1; #1;
        tests_run++; if (RDATA !== 32'h1234) begin tests_failed++; $display("FAIL fl_cap_hi: got %h exp 1234", RDATA); end
        RD_HI = 0;
    endtask

    task automatic test_mt_mf();
        bit to, sb;
        int cyc;
        @(negedge CLK); MTLO = 1; WDATA = 32'hDEAD;
        @(negedge CLK); MTLO = 0; RD_LO = 1; #1;
        tests_run++; if (STALL !== 1'b0 || RDATA !== 32'hDEAD) begin tests_failed++; $display("FAIL mtlo_rd: got %b/%h exp 0/dead", STALL, RDATA); end
        RD_LO = 0;
        lat = 4;
        @(negedge CLK); REQ = 1; REQ_SGN = 0; OPA = 32'd2; OPB = 32'd3;
        @(negedge CLK); REQ = 0; MTHI = 1; WDATA = 32'hBEEF; #1;
        tests_run++; if (STALL !== 1'b1) begin tests_failed++; $display("FAIL mthi_stall: got %b exp 1", STALL); end
        wait_idle(60, to, cyc, sb);
        tests_run++; if (to !== 1'b0 || sb !== 1'b0 || STALL !== 1'b0) begin tests_failed++; $display("FAIL mthi_release: got timeout %b drop %b stall %b exp 0 0 0", to, sb, STALL); end
        @(negedge CLK); MTHI = 0; RD_HI = 1; #1;
        tests_run++; if (RDATA !== 32'hBEEF) begin tests_failed++; $display("FAIL mthi_hi: got %h exp beef", RDATA); end
        RD_HI = 0; #1;
        tests_run++; if (RDATA !== 32'h6) begin tests_failed++; $display("FAIL mthi_lo: got %h exp 6", RDATA); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_flush();
        test_mt_mf();
        repeat (2) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
